battleship_turn_ctrl: RTL and testbench

Game sequencer for the Battleship master board. It latches both fleets, enforces alternating one-shot turns, scores hits, and hands each accepted shot to the link layer through a valid/ready port. It sits between the player switch/button inputs and the UART link toward the slave board, and replaces ad-hoc turn logic in the top level.

---
 rtl/battleship_pkg.sv | 39 +++
 rtl/battleship_btn_edge.sv | 35 +++
 rtl/battleship_turn_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battleship_pkg
// Description : Shared constants, state encoding, winner encoding and a
//               popcount helper for the Battleship turn controller.
// Revision    : 1.0 - initial release
// ============================================================================
package battleship_pkg;

  localparam int N_CELLS_DEF    = 16;
  localparam int SHIP_CELLS_DEF = 7;

  // Popcount result width; covers boards of up to 32 cells.
  localparam int POP_W = 6;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_A_TURN    = 3'd1,
    ST_A_SEND    = 3'd2,
    ST_B_TURN    = 3'd3,
    ST_B_SEND    = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/battleship_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : battleship_btn_edge
// Description : Registers a button level and emits a one-cycle press strobe
//               on its rising edge.
// Ports       : clk, clr (async, active-high), i_level (button level),
//               o_press (combinational strobe, valid at the acting edge)
// Revision    : 1.0 - initial release
// ============================================================================
module battleship_btn_edge (
  input  logic clk,
  input  logic clr,
  input  logic i_level,
  output logic o_press
);

  logic r_prev;
  logic r_armed;

  // r_armed stays low for the first edge after reset, so a button already
  // held down when reset releases is absorbed into r_prev, not seen as a press.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_press = i_level & ~r_prev & r_armed;

endmodule
`default_nettype wire

// File: rtl/battleship_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : battleship_turn_ctrl
// Description : Battleship game sequencer. Latches both fleets, alternates
//               one-shot turns, scores hits and hands each accepted shot to
//               the link layer over a valid/ready port.
// Ports       : clk, clr (async, active-high)
//               sw_a/sw_b          switch banks (fleet, then cumulative shots)
//               btn_ready_a/b      fleet confirm, btn_fire_a/b shot commit,
//               btn_new            restart (GAME_OVER only)
//               tx_ready/tx_valid/tx_data/tx_player/tx_hit  shot handoff
//               state_o, hits_a/b, err (1-cycle reject pulse), winner
// Revision    : 1.0 - initial release
// ============================================================================
module battleship_turn_ctrl
  import battleship_pkg::*;
#(
  parameter int N_CELLS    = N_CELLS_DEF,
  parameter int SHIP_CELLS = SHIP_CELLS_DEF
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic [N_CELLS-1:0]                sw_a,
  input  logic [N_CELLS-1:0]                sw_b,
  input  logic                              btn_ready_a,
  input  logic                              btn_ready_b,
  input  logic                              btn_fire_a,
  input  logic                              btn_fire_b,
  input  logic                              btn_new,
  input  logic                              tx_ready,
  output logic                              tx_valid,
  output logic [N_CELLS-1:0]                tx_data,
  output logic                              tx_player,
  output logic                              tx_hit,
  output logic [2:0]                        state_o,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_a,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_b,
  output logic                              err,
  output logic [1:0]                        winner
);

  localparam int              HITS_W   = $clog2(SHIP_CELLS + 1);
  localparam logic [HITS_W-1:0] HITS_MAX = HITS_W'(SHIP_CELLS);
  localparam logic [POP_W-1:0]  POP_SHIP = POP_W'(SHIP_CELLS);
  localparam logic [POP_W-1:0]  POP_ONE  = POP_W'(1);

  // ---------------------------------------------------------------- presses
  logic w_prs_rdy_a, w_prs_rdy_b, w_prs_fire_a, w_prs_fire_b, w_prs_new;

  battleship_btn_edge u_edge_rdy_a  (.clk(clk), .clr(clr), .i_level(btn_ready_a), .o_press(w_prs_rdy_a));
  battleship_btn_edge u_edge_rdy_b  (.clk(clk), .clr(clr), .i_level(btn_ready_b), .o_press(w_prs_rdy_b));
  battleship_btn_edge u_edge_fire_a (.clk(clk), .clr(clr), .i_level(btn_fire_a),  .o_press(w_prs_fire_a));
  battleship_btn_edge u_edge_fire_b (.clk(clk), .clr(clr), .i_level(btn_fire_b),  .o_press(w_prs_fire_b));
  battleship_btn_edge u_edge_new    (.clk(clk), .clr(clr), .i_level(btn_new),     .o_press(w_prs_new));

  // ---------------------------------------------------------------- state
  state_e              r_state,     w_state_nxt;
  logic [N_CELLS-1:0]  r_fleet_a,   w_fleet_a_nxt;
  logic [N_CELLS-1:0]  r_fleet_b,   w_fleet_b_nxt;
  logic [N_CELLS-1:0]  r_shots_a,   w_shots_a_nxt;
  logic [N_CELLS-1:0]  r_shots_b,   w_shots_b_nxt;
  logic                r_rdy_a,     w_rdy_a_nxt;
  logic                r_rdy_b,     w_rdy_b_nxt;
  logic [HITS_W-1:0]   r_hits_a,    w_hits_a_nxt;
  logic [HITS_W-1:0]   r_hits_b,    w_hits_b_nxt;
  logic                r_err,       w_err_nxt;
  logic [1:0]          r_winner,    w_winner_nxt;
  logic [N_CELLS-1:0]  r_tx_data,   w_tx_data_nxt;
  logic                r_tx_player, w_tx_player_nxt;
  logic                r_tx_hit,    w_tx_hit_nxt;

  // ---------------------------------------------------------------- shot evaluation
  logic                w_legal_a, w_legal_b;
  logic [N_CELLS-1:0]  w_new_a, w_new_b;
  logic                w_ok_a, w_ok_b;
  logic                w_hit_a, w_hit_b;
  logic                w_sunk_a, w_sunk_b;
  logic [HITS_W-1:0]   w_hits_a_inc, w_hits_b_inc;

  assign w_legal_a = (popcount(32'(sw_a)) == POP_SHIP);
  assign w_legal_b = (popcount(32'(sw_b)) == POP_SHIP);

  // A shot is legal only when exactly one new switch is up and every
  // previously fired switch is still up (shots are cumulative on the bank).
  assign w_new_a = sw_a & ~r_shots_a;
  assign w_new_b = sw_b & ~r_shots_b;
  assign w_ok_a  = (popcount(32'(w_new_a)) == POP_ONE) && ((sw_a & r_shots_a) == r_shots_a);
  assign w_ok_b  = (popcount(32'(w_new_b)) == POP_ONE) && ((sw_b & r_shots_b) == r_shots_b);
  assign w_hit_a = |(w_new_a & r_fleet_b);
  assign w_hit_b = |(w_new_b & r_fleet_a);

  // Evaluated in SEND, where r_shots_x already includes the shot in flight.
  assign w_sunk_a = ((r_shots_a & r_fleet_b) == r_fleet_b);
  assign w_sunk_b = ((r_shots_b & r_fleet_a) == r_fleet_a);

  assign w_hits_a_inc = (r_hits_a == HITS_MAX) ? r_hits_a : r_hits_a + 1'b1;
  assign w_hits_b_inc = (r_hits_b == HITS_MAX) ? r_hits_b : r_hits_b + 1'b1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_LOAD;
      r_fleet_a   <= '0;
      r_fleet_b   <= '0;
      r_shots_a   <= '0;
      r_shots_b   <= '0;
      r_rdy_a     <= 1'b0;
      r_rdy_b     <= 1'b0;
      r_hits_a    <= '0;
      r_hits_b    <= '0;
      r_err       <= 1'b0;
      r_winner    <= WIN_NONE;
      r_tx_data   <= '0;
      r_tx_player <= 1'b0;
      r_tx_hit    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fleet_a   <= w_fleet_a_nxt;
      r_fleet_b   <= w_fleet_b_nxt;
      r_shots_a   <= w_shots_a_nxt;
      r_shots_b   <= w_shots_b_nxt;
      r_rdy_a     <= w_rdy_a_nxt;
      r_rdy_b     <= w_rdy_b_nxt;
      r_hits_a    <= w_hits_a_nxt;
      r_hits_b    <= w_hits_b_nxt;
      r_err       <= w_err_nxt;
      r_winner    <= w_winner_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_player <= w_tx_player_nxt;
      r_tx_hit    <= w_tx_hit_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fleet_a_nxt   = r_fleet_a;
    w_fleet_b_nxt   = r_fleet_b;
    w_shots_a_nxt   = r_shots_a;
    w_shots_b_nxt   = r_shots_b;
    w_rdy_a_nxt     = r_rdy_a;
    w_rdy_b_nxt     = r_rdy_b;
    w_hits_a_nxt    = r_hits_a;
    w_hits_b_nxt    = r_hits_b;
    w_err_nxt       = 1'b0;
    w_winner_nxt    = r_winner;
    w_tx_data_nxt   = r_tx_data;
    w_tx_player_nxt = r_tx_player;
    w_tx_hit_nxt    = r_tx_hit;

    unique case (r_state)
      ST_LOAD: begin
        if (w_prs_rdy_a) begin
          if (w_legal_a) begin
            w_fleet_a_nxt = sw_a;
            w_rdy_a_nxt   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        if (w_prs_rdy_b) begin
          if (w_legal_b) begin
            w_fleet_b_nxt = sw_b;
            w_rdy_b_nxt   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        // Uses the next-cycle flags so a confirm on this edge can complete LOAD.
        if (w_rdy_a_nxt && w_rdy_b_nxt) begin
          w_state_nxt   = ST_A_TURN;
          w_shots_a_nxt = '0;
          w_shots_b_nxt = '0;
        end
      end

      ST_A_TURN: begin
        if (w_prs_fire_a) begin
          if (w_ok_a) begin
            w_shots_a_nxt   = r_shots_a | w_new_a;
            w_tx_data_nxt   = w_new_a;
            w_tx_player_nxt = 1'b0;
            w_tx_hit_nxt    = w_hit_a;
            if (w_hit_a) w_hits_a_nxt = w_hits_a_inc;
            w_state_nxt     = ST_A_SEND;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_A_SEND: begin
        if (tx_ready) begin
          if (w_sunk_a) begin
            w_winner_nxt = WIN_A;
            w_state_nxt  = ST_GAME_OVER;
          end else begin
            w_state_nxt  = ST_B_TURN;
          end
        end
      end

      ST_B_TURN: begin
        if (w_prs_fire_b) begin
          if (w_ok_b) begin
            w_shots_b_nxt   = r_shots_b | w_new_b;
            w_tx_data_nxt   = w_new_b;
            w_tx_player_nxt = 1'b1;
            w_tx_hit_nxt    = w_hit_b;
            if (w_hit_b) w_hits_b_nxt = w_hits_b_inc;
            w_state_nxt     = ST_B_SEND;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_B_SEND: begin
        if (tx_ready) begin
          if (w_sunk_b) begin
            w_winner_nxt = WIN_B;
            w_state_nxt  = ST_GAME_OVER;
          end else begin
            w_state_nxt  = ST_A_TURN;
          end
        end
      end

      ST_GAME_OVER: begin
        if (w_prs_new) begin
          w_fleet_a_nxt   = '0;
          w_fleet_b_nxt   = '0;
          w_shots_a_nxt   = '0;
          w_shots_b_nxt   = '0;
          w_rdy_a_nxt     = 1'b0;
          w_rdy_b_nxt     = 1'b0;
          w_hits_a_nxt    = '0;
          w_hits_b_nxt    = '0;
          w_winner_nxt    = WIN_NONE;
          w_tx_data_nxt   = '0;
          w_tx_player_nxt = 1'b0;
          w_tx_hit_nxt    = 1'b0;
          w_state_nxt     = ST_LOAD;
        end
      end

      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign tx_valid  = (r_state == ST_A_SEND) || (r_state == ST_B_SEND);
  assign tx_data   = r_tx_data;
  assign tx_player = r_tx_player;
  assign tx_hit    = r_tx_hit;
  assign state_o   = r_state;
  assign hits_a    = r_hits_a;
  assign hits_b    = r_hits_b;
  assign err       = r_err;
  assign winner    = r_winner;

  // A hit needs a new cell of the opponent's fleet, so the counters can
  // never pass the fleet size.
  a_hits_sat: assert property (@(posedge clk) disable iff (clr)
                               (r_hits_a <= HITS_MAX) && (r_hits_b <= HITS_MAX));

endmodule
`default_nettype wire

// File: tb/tb_battleship_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_battleship_turn_ctrl
// Description : Self-checking bench for battleship_turn_ctrl. Each accepted
//               shot pushes its expected handoff to a scoreboard queue; a
//               monitor pops and compares on every valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battleship_turn_ctrl;
  import battleship_pkg::*;

  localparam int NC = 16;
  localparam int SC = 7;
  localparam int HW = $clog2(SC + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [NC-1:0] sw_a = '0, sw_b = '0;
  logic          btn_ready_a = 1'b0, btn_ready_b = 1'b0;
  logic          btn_fire_a = 1'b0, btn_fire_b = 1'b0, btn_new = 1'b0;
  logic          tx_ready = 1'b0;
  logic          tx_valid, tx_player, tx_hit, err;
  logic [NC-1:0] tx_data;
  logic [2:0]    state_o;
  logic [HW-1:0] hits_a, hits_b;
  logic [1:0]    winner;

  battleship_turn_ctrl #(.N_CELLS(NC), .SHIP_CELLS(SC)) dut (
    .clk(clk), .clr(clr),
    .sw_a(sw_a), .sw_b(sw_b),
    .btn_ready_a(btn_ready_a), .btn_ready_b(btn_ready_b),
    .btn_fire_a(btn_fire_a), .btn_fire_b(btn_fire_b), .btn_new(btn_new),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_player(tx_player), .tx_hit(tx_hit), .state_o(state_o),
    .hits_a(hits_a), .hits_b(hits_b), .err(err), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] data;
    logic          player;
    logic          hit;
  } tx_t;

  tx_t           sb[$];
  tx_t           r_mon_e;
  int            n_chk = 0;
  int            n_err = 0;
  int            n_hs  = 0;
  int            exp_hs = 0;
  logic [NC-1:0] m_fleet[2];
  logic [NC-1:0] m_shots[2];
  int            a_bits[7] = '{1, 2, 5, 6, 7, 12, 13};
  int            b_bits[7] = '{0, 3, 4, 5, 6, 7, 8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0 ready_a, 1 ready_b, 2 fire_a, 3 fire_b, 4 new
  task automatic press(input logic [4:0] m);
    {btn_new, btn_fire_b, btn_fire_a, btn_ready_b, btn_ready_a} = m;
    tick();
    {btn_new, btn_fire_b, btn_fire_a, btn_ready_b, btn_ready_a} = 5'b0;
  endtask

  // Drives a legal shot and records its expected handoff.
  task automatic fire(input int pl, input logic [NC-1:0] sw, input logic rdy);
    tx_t           e;
    logic [NC-1:0] nw;
    nw       = sw & ~m_shots[pl];
    e.data   = nw;
    e.player = pl[0];
    e.hit    = |(nw & m_fleet[1-pl]);
    sb.push_back(e);
    exp_hs++;
    m_shots[pl] = m_shots[pl] | nw;
    if (pl == 0) sw_a = sw; else sw_b = sw;
    tx_ready = rdy;
    press(pl == 0 ? 5'b00100 : 5'b01000);
  endtask

  always @(negedge clk) begin
    if (!clr && tx_valid && tx_ready) begin
      n_hs++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        r_mon_e = sb.pop_front();
        chk("hs_tx_data", 32'(tx_data), 32'(r_mon_e.data));
        chk("hs_tx_player", 32'(tx_player), 32'(r_mon_e.player));
        chk("hs_tx_hit", 32'(tx_hit), 32'(r_mon_e.hit));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_fleet[0] = '0; m_fleet[1] = '0;
    m_shots[0] = '0; m_shots[1] = '0;
    btn_ready_a = 1'b1;  // held through reset release, with an illegal fleet
    repeat (2) tick();
    chk("rst_state", 32'(state_o), 32'(ST_LOAD));
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_player", 32'(tx_player), 32'd0);
    chk("rst_tx_hit", 32'(tx_hit), 32'd0);
    chk("rst_hits_a", 32'(hits_a), 32'd0);
    chk("rst_hits_b", 32'(hits_b), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);

    clr = 1'b0;
    tick();
    chk("held_btn_err1", 32'(err), 32'd0);
    tick();
    chk("held_btn_err2", 32'(err), 32'd0);
    chk("held_btn_state", 32'(state_o), 32'(ST_LOAD));
    btn_ready_a = 1'b0;
    tick();

    // Load: A legal, B has 8 cells.
    sw_a = 16'hE606; sw_b = 16'h30E7;
    press(5'b00011);
    chk("load_bad_err", 32'(err), 32'd1);
    chk("load_bad_state", 32'(state_o), 32'(ST_LOAD));
    tick();
    chk("err_one_cycle", 32'(err), 32'd0);
    sw_b = 16'h30E6;
    press(5'b00010);
    chk("load_ok_state", 32'(state_o), 32'(ST_A_TURN));
    chk("load_ok_err", 32'(err), 32'd0);
    m_fleet[0] = 16'hE606; m_fleet[1] = 16'h30E6;

    // First A shot, link ready.
    fire(0, 16'h8000, 1'b1);
    chk("a1_state", 32'(state_o), 32'(ST_A_SEND));
    chk("a1_valid", 32'(tx_valid), 32'd1);
    chk("a1_data", 32'(tx_data), 32'h8000);
    chk("a1_player", 32'(tx_player), 32'd0);
    chk("a1_hit", 32'(tx_hit), 32'd0);
    tick();
    chk("a1_next_state", 32'(state_o), 32'(ST_B_TURN));
    chk("a1_valid_drop", 32'(tx_valid), 32'd0);

    fire(1, 16'h0001, 1'b1);
    chk("b1_state", 32'(state_o), 32'(ST_B_SEND));
    chk("b1_player", 32'(tx_player), 32'd1);
    tick();
    chk("b1_next_state", 32'(state_o), 32'(ST_A_TURN));

    // Rejected A shots and an ignored B press.
    sw_a = 16'hC002;
    press(5'b00100);
    chk("two_new_err", 32'(err), 32'd1);
    chk("two_new_state", 32'(state_o), 32'(ST_A_TURN));
    tick();
    sw_a = 16'h0002;
    press(5'b00100);
    chk("cleared_shot_err", 32'(err), 32'd1);
    tick();
    sw_b = 16'h0003;
    press(5'b01000);
    chk("b_ignored_err", 32'(err), 32'd0);
    chk("b_ignored_state", 32'(state_o), 32'(ST_A_TURN));
    tick();

    // A hit with the link stalled.
    fire(0, m_shots[0] | (16'h1 << a_bits[0]), 1'b0);
    chk("a2_state", 32'(state_o), 32'(ST_A_SEND));
    chk("a2_hit", 32'(tx_hit), 32'd1);
    chk("a2_hits_a", 32'(hits_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) btn_fire_a = 1'b1;
      if (i == 3) btn_fire_b = 1'b1;
      tick();
      btn_fire_a = 1'b0; btn_fire_b = 1'b0;
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'h0002);
      chk("stall_state", 32'(state_o), 32'(ST_A_SEND));
      chk("stall_err", 32'(err), 32'd0);
    end
    tx_ready = 1'b1;
    tick();
    chk("stall_release", 32'(state_o), 32'(ST_B_TURN));

    // Remaining turns: B always misses, A sinks the fleet.
    for (int k = 1; k < 7; k++) begin
      fire(1, m_shots[1] | (16'h1 << b_bits[k]), 1'b1);
      tick();
      chk("loop_b_to_a", 32'(state_o), 32'(ST_A_TURN));
      fire(0, m_shots[0] | (16'h1 << a_bits[k]), 1'b1);
      chk("loop_hits_a", 32'(hits_a), 32'(k + 1));
      tick();
      if (k == 6) chk("loop_end_state", 32'(state_o), 32'(ST_GAME_OVER));
      else        chk("loop_next_state", 32'(state_o), 32'(ST_B_TURN));
    end
    chk("go_winner", 32'(winner), 32'(WIN_A));
    chk("go_hits_a", 32'(hits_a), 32'd7);
    chk("go_hits_b", 32'(hits_b), 32'd0);
    repeat (2) tick();
    chk("go_hold_winner", 32'(winner), 32'(WIN_A));
    chk("go_hold_state", 32'(state_o), 32'(ST_GAME_OVER));

    press(5'b10000);
    chk("new_state", 32'(state_o), 32'(ST_LOAD));
    chk("new_hits_a", 32'(hits_a), 32'd0);
    chk("new_winner", 32'(winner), 32'(WIN_NONE));

    // Second game, then reset in the middle of a B transfer.
    m_shots[0] = '0; m_shots[1] = '0;
    sw_a = 16'hE606; sw_b = 16'h30E6;
    press(5'b00011);
    chk("reload_state", 32'(state_o), 32'(ST_A_TURN));
    fire(0, 16'h0001, 1'b1);
    tick();
    fire(1, 16'h0001, 1'b0);
    chk("bsend_valid", 32'(tx_valid), 32'd1);
    chk("bsend_state", 32'(state_o), 32'(ST_B_SEND));
    #2 clr = 1'b1;
    #1;
    chk("aclr_state", 32'(state_o), 32'(ST_LOAD));
    chk("aclr_valid", 32'(tx_valid), 32'd0);
    chk("aclr_data", 32'(tx_data), 32'd0);
    chk("aclr_player", 32'(tx_player), 32'd0);
    chk("aclr_hit", 32'(tx_hit), 32'd0);
    chk("aclr_hits_a", 32'(hits_a), 32'd0);
    chk("aclr_winner", 32'(winner), 32'd0);
    exp_hs = exp_hs - sb.size();
    sb.delete();
    tick();
    clr = 1'b0;
    repeat (2) tick();
    chk("post_clr_state", 32'(state_o), 32'(ST_LOAD));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("handshakes", 32'(n_hs), 32'(exp_hs));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
